// File: rtl/sd_cmd_wb_sequencer_if.sv
// Bundle of the command request, response stream and Wishbone byte-master
// signals of the SD command sequencer. The master modport is the sequencer's
// view; the slave modport is the view of whatever sits around it.
interface sd_cmd_wb_sequencer_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [5:0]  cmd_idx_i;
    logic [31:0] cmd_arg_i;
    logic [4:0]  cmd_rsp_len_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [7:0]  rsp_data_o;
    logic        rsp_last_o;

    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_we_o;
    logic [2:0]  m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic [7:0]  m_wb_dat_o;
    logic [7:0]  m_wb_dat_i;
    logic        m_wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_idx_i, cmd_arg_i, cmd_rsp_len_i,
        input  rsp_ready_i, m_wb_dat_i, m_wb_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o,
        output m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_sel_o, m_wb_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_idx_i, cmd_arg_i, cmd_rsp_len_i,
        output rsp_ready_i, m_wb_dat_i, m_wb_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_last_o,
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o, m_wb_sel_o, m_wb_dat_o
    );
endinterface

// File: rtl/sd_cmd_wb_sequencer.sv
// SD command sequencer: frames one SD command (with CRC7), writes it byte by
// byte into the FIFO controller's tx command FIFO over Wishbone, then drains
// the response bytes from the rx command FIFO and streams them out.
module sd_cmd_wb_sequencer #(
    parameter int POLL_LIMIT = 1024,
    parameter int PW         = 11
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    sd_cmd_wb_sequencer_if.master        bus_io,
    output logic                         done_o,
    output logic                         err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_TXCHK, S_TXWR, S_RXCHK, S_RXRD, S_OUT, S_FIN, S_TOUT
    } state_t;

    localparam logic [2:0] ADR_TX   = 3'd0;
    localparam logic [2:0] ADR_RX   = 3'd1;
    localparam logic [2:0] ADR_STAT = 3'd4;
    localparam logic [5:0] CRC_BITS = 6'd40;

    // One MSB-first step of the CRC7 LFSR, G(x) = x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // Byte i of the 6-byte command frame.
    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic [6:0] crc);
        case (i)
            3'd0:    return {2'b01, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return {crc, 1'b1};
        endcase
    endfunction

    // Response length saturates at the R2 size.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'd17) ? 5'd17 : len;
    endfunction

    state_t        state_q, state_d;
    logic          rdy_q, rdy_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [2:0]    adr_q, adr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic [7:0]    rsp_q, rsp_d;
    logic [2:0]    i_q, i_d;
    logic [4:0]    j_q, j_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [5:0]    crc_cnt_q, crc_cnt_d;
    logic [5:0]    idx_q, idx_d;
    logic [31:0]   arg_q, arg_d;
    logic [4:0]    len_q, len_d;
    logic [6:0]    crc_q, crc_d;

    logic [39:0]   msg;
    logic [5:0]    bit_sel;
    logic [PW-1:0] poll_inc;
    logic          poll_hit;
    logic          last_byte;

    assign msg       = {2'b01, idx_q, arg_q};
    assign bit_sel   = 6'd39 - crc_cnt_q;
    assign poll_inc  = poll_q + PW'(1);
    assign poll_hit  = (poll_inc == PW'(POLL_LIMIT));
    assign last_byte = (j_q == len_q - 5'd1);

    assign bus_io.cmd_ready_o = rdy_q;
    assign bus_io.rsp_valid_o = (state_q == S_OUT);
    assign bus_io.rsp_data_o  = rsp_q;
    assign bus_io.rsp_last_o  = (state_q == S_OUT) && last_byte;
    assign bus_io.m_wb_cyc_o  = stb_q;
    assign bus_io.m_wb_stb_o  = stb_q;
    assign bus_io.m_wb_we_o   = we_q;
    assign bus_io.m_wb_adr_o  = adr_q;
    assign bus_io.m_wb_sel_o  = 4'b0001;
    assign bus_io.m_wb_dat_o  = wdat_q;
    assign done_o             = (state_q == S_FIN) || (state_q == S_TOUT);
    assign err_timeout_o      = (state_q == S_TOUT);

    // Next-state logic: command sequencing, bus accesses and background CRC.
    // Every bus access starts from stb low, so after each ack edge there is
    // at least one idle cycle before the next strobe.
    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rsp_d     = rsp_q;
        i_d       = i_q;
        j_d       = j_q;
        poll_d    = poll_q;
        crc_cnt_d = crc_cnt_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        len_d     = len_q;
        crc_d     = crc_q;

        if (crc_cnt_q != CRC_BITS) begin
            crc_d     = crc7_step(crc_q, msg[bit_sel]);
            crc_cnt_d = crc_cnt_q + 6'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (rdy_q && bus_io.cmd_valid_i) begin
                    idx_d     = bus_io.cmd_idx_i;
                    arg_d     = bus_io.cmd_arg_i;
                    len_d     = clamp_len(bus_io.cmd_rsp_len_i);
                    i_d       = 3'd0;
                    poll_d    = '0;
                    crc_d     = 7'd0;
                    crc_cnt_d = 6'd0;
                    state_d   = S_TXCHK;
                end
            end
            S_TXCHK: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = ADR_STAT;
                end else if (bus_io.m_wb_ack_i) begin
                    stb_d = 1'b0;
                    if (bus_io.m_wb_dat_i[0]) begin
                        poll_d = poll_inc;
                        if (poll_hit) state_d = S_TOUT;
                    end else begin
                        state_d = S_TXWR;
                    end
                end
            end
            S_TXWR: begin
                if (!stb_q) begin
                    // The CRC byte must wait for the serial CRC to finish.
                    if (i_q != 3'd5 || crc_cnt_q == CRC_BITS) begin
                        stb_d  = 1'b1;
                        we_d   = 1'b1;
                        adr_d  = ADR_TX;
                        wdat_d = frame_byte(i_q, idx_q, arg_q, crc_q);
                    end
                end else if (bus_io.m_wb_ack_i) begin
                    stb_d  = 1'b0;
                    we_d   = 1'b0;
                    poll_d = '0;
                    if (i_q != 3'd5) begin
                        i_d     = i_q + 3'd1;
                        state_d = S_TXCHK;
                    end else if (len_q == 5'd0) begin
                        state_d = S_FIN;
                    end else begin
                        j_d     = 5'd0;
                        state_d = S_RXCHK;
                    end
                end
            end
            S_RXCHK: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = ADR_STAT;
                end else if (bus_io.m_wb_ack_i) begin
                    stb_d = 1'b0;
                    if (bus_io.m_wb_dat_i[1]) begin
                        poll_d = poll_inc;
                        if (poll_hit) state_d = S_TOUT;
                    end else begin
                        state_d = S_RXRD;
                    end
                end
            end
            S_RXRD: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = ADR_RX;
                end else if (bus_io.m_wb_ack_i) begin
                    stb_d   = 1'b0;
                    rsp_d   = bus_io.m_wb_dat_i;
                    poll_d  = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus_io.rsp_ready_i) begin
                    j_d     = j_q + 5'd1;
                    state_d = last_byte ? S_FIN : S_RXCHK;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_TOUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rdy_d = (state_d == S_IDLE);
    end

    // Control and output registers; reset returns to IDLE and drops the bus.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 3'd0;
            wdat_q    <= 8'd0;
            rsp_q     <= 8'd0;
            i_q       <= 3'd0;
            j_q       <= 5'd0;
            poll_q    <= '0;
            crc_cnt_q <= CRC_BITS;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rsp_q     <= rsp_d;
            i_q       <= i_d;
            j_q       <= j_d;
            poll_q    <= poll_d;
            crc_cnt_q <= crc_cnt_d;
        end
    end

    // Latched command copy and CRC accumulator; only meaningful after accept.
    always_ff @(posedge wb_clk_i) begin
        idx_q <= idx_d;
        arg_q <= arg_d;
        len_q <= len_d;
        crc_q <= crc_d;
    end

endmodule

// File: tb/tb_sd_cmd_wb_sequencer.sv
// Bench for sd_cmd_wb_sequencer: behavioural Wishbone FIFO-controller slave,
// scoreboard queues for tx frame bytes, response bytes and command completion.
module tb_sd_cmd_wb_sequencer;
    localparam int PL = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic done, err;

    sd_cmd_wb_sequencer_if bus_if();

    sd_cmd_wb_sequencer #(.POLL_LIMIT(PL), .PW(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .bus_io       (bus_if),
        .done_o       (done),
        .err_timeout_o(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard
    logic [7:0]  exp_tx[$];
    logic [8:0]  exp_rsp[$];
    bit          exp_done_err[$];
    int          exp_done_reads[$];
    logic [7:0]  rx_fixed[$];

    // slave model state
    logic [7:0]  rxq[$];
    int          rx_busy_q[$];
    int          rx_busy_left = 0;
    bit          rx_never = 0;
    int          tx_busy_pos = -1, tx_busy_left = 0;
    int          tx_writes = 0, stat_reads = 0;
    int          lat_min = 1, lat_max = 3, cur_lat = 1, wait_cnt = 0;

    // consumer model state
    int          stall_byte = -1, stall_len = 0, stall_cnt = 0, rsp_idx = 0;
    bit          rdy_rand = 0;

    int          done_cnt = 0, done_any = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC7 by polynomial long division of msg * x^7 by 0x89.
    function automatic logic [6:0] ref_crc7(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int b = 46; b >= 7; b--)
            if (r[b]) r[b -: 8] = r[b -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic slave_access();
        logic [7:0] s;
        if (bus_if.m_wb_we_o) begin
            tx_writes++;
        end else if (bus_if.m_wb_adr_o == 3'd4) begin
            stat_reads++;
            s = 8'($urandom);
            if (tx_writes < 6) begin
                s[0] = (tx_writes == tx_busy_pos) && (tx_busy_left > 0);
                if (s[0]) tx_busy_left--;
            end else begin
                s[1] = rx_never || (rx_busy_left > 0) || (rxq.size() == 0);
                if (!rx_never && rx_busy_left > 0) rx_busy_left--;
            end
            bus_if.m_wb_dat_i = s;
        end else if (bus_if.m_wb_adr_o == 3'd1) begin
            bus_if.m_wb_dat_i = (rxq.size() > 0) ? rxq.pop_front() : 8'($urandom);
            rx_busy_left = (rx_busy_q.size() > 0) ? rx_busy_q.pop_front() : 0;
        end else begin
            bus_if.m_wb_dat_i = 8'($urandom);
        end
    endtask

    // Wishbone slave: ack after a random latency, one-cycle ack pulse.
    initial begin
        bus_if.m_wb_ack_i = 1'b0;
        bus_if.m_wb_dat_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || bus_if.m_wb_ack_i) begin
                bus_if.m_wb_ack_i = 1'b0;
                wait_cnt = 0;
            end else if (bus_if.m_wb_stb_o) begin
                if (wait_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
                wait_cnt++;
                if (wait_cnt >= cur_lat) begin
                    bus_if.m_wb_ack_i = 1'b1;
                    slave_access();
                end
            end
        end
    end

    // Response consumer.
    initial begin
        bus_if.rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_byte == rsp_idx && stall_cnt < stall_len) begin
                bus_if.rsp_ready_i = 1'b0;
                if (bus_if.rsp_valid_o) stall_cnt++;
            end else if (rdy_rand) begin
                bus_if.rsp_ready_i = ($urandom_range(3, 0) != 0);
            end else begin
                bus_if.rsp_ready_i = 1'b1;
            end
        end
    end

    // Monitor: protocol checks and scoreboard pops, sampled mid-cycle.
    initial begin
        logic [11:0] prev_bus;
        logic [8:0]  prev_rsp;
        logic [31:0] e;
        bit prev_wait, prev_ack, prev_hold, prev_rdychk;
        prev_bus = '0; prev_rsp = '0;
        prev_wait = 0; prev_ack = 0; prev_hold = 0; prev_rdychk = 0;
        forever begin
            @(negedge clk);
            if (done) done_any++;
            if (rst_n) begin
                if (bus_if.m_wb_stb_o || bus_if.m_wb_cyc_o) begin
                    chk("cyc_eq_stb", 32'(bus_if.m_wb_cyc_o), 32'(bus_if.m_wb_stb_o));
                    chk("sel_const", 32'(bus_if.m_wb_sel_o), 32'h1);
                end
                if (prev_wait && bus_if.m_wb_stb_o)
                    chk("bus_stable", 32'({bus_if.m_wb_adr_o, bus_if.m_wb_we_o, bus_if.m_wb_dat_o}), 32'(prev_bus));
                if (prev_ack) chk("gap_after_ack", 32'(bus_if.m_wb_stb_o), 32'h0);
                if (bus_if.rsp_valid_o) chk("bus_idle_in_out", 32'(bus_if.m_wb_stb_o), 32'h0);
                if (prev_hold)
                    chk("rsp_hold", 32'({bus_if.rsp_valid_o, bus_if.rsp_last_o, bus_if.rsp_data_o}), 32'({1'b1, prev_rsp}));
                if (bus_if.m_wb_stb_o && bus_if.m_wb_ack_i && bus_if.m_wb_we_o) begin
                    e = (exp_tx.size() > 0) ? 32'({3'd0, exp_tx.pop_front()}) : 32'hFFFF_FFFF;
                    chk("tx_byte", 32'({bus_if.m_wb_adr_o, bus_if.m_wb_dat_o}), e);
                end
                if (bus_if.rsp_valid_o && bus_if.rsp_ready_i) begin
                    e = (exp_rsp.size() > 0) ? 32'(exp_rsp.pop_front()) : 32'hFFFF_FFFF;
                    chk("rsp_byte", 32'({bus_if.rsp_last_o, bus_if.rsp_data_o}), e);
                    rsp_idx++;
                end
                if (prev_rdychk) chk("ready_after_done", 32'(bus_if.cmd_ready_o), 32'h1);
                prev_rdychk = 0;
                if (done) begin
                    e = (exp_done_err.size() > 0) ? 32'(exp_done_err.pop_front()) : 32'hFFFF_FFFF;
                    chk("done_err", 32'(err), e);
                    e = (exp_done_reads.size() > 0) ? 32'(exp_done_reads.pop_front()) : 32'hFFFF_FFFF;
                    chk("status_reads", 32'(stat_reads), e);
                    chk("rsp_all_out", 32'(exp_rsp.size()), 32'h0);
                    done_cnt++;
                    prev_rdychk = 1;
                end else if (err) begin
                    chk("err_without_done", 32'(err), 32'h0);
                end
                prev_wait = bus_if.m_wb_stb_o && !bus_if.m_wb_ack_i;
                prev_ack  = bus_if.m_wb_stb_o && bus_if.m_wb_ack_i;
                prev_bus  = {bus_if.m_wb_adr_o, bus_if.m_wb_we_o, bus_if.m_wb_dat_o};
                prev_hold = bus_if.rsp_valid_o && !bus_if.rsp_ready_i;
                prev_rsp  = {bus_if.rsp_last_o, bus_if.rsp_data_o};
            end else begin
                prev_wait = 0; prev_ack = 0; prev_hold = 0; prev_rdychk = 0;
            end
        end
    end

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [4:0] len,
                           input int txp, input int txn, input bit never,
                           input bit use_b5, input logic [7:0] b5, input bit wait_done);
        int n, k, sum, rb, d0;
        logic [7:0] f[6];
        logic [7:0] d;
        n = (len > 5'd17) ? 17 : int'(len);
        k = 0;
        while (bus_if.cmd_ready_o !== 1'b1 && k < 500) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 500) begin
            chk("cmd_ready_wait", 32'(bus_if.cmd_ready_o), 32'h1);
            return;
        end
        f[0] = {2'b01, idx};
        f[1] = arg[31:24]; f[2] = arg[23:16]; f[3] = arg[15:8]; f[4] = arg[7:0];
        f[5] = use_b5 ? b5 : {ref_crc7({2'b01, idx, arg}), 1'b1};
        for (int q = 0; q < 6; q++) exp_tx.push_back(f[q]);
        tx_writes = 0; stat_reads = 0;
        tx_busy_pos = txp; tx_busy_left = txn;
        rx_never = never; rxq.delete(); rx_busy_q.delete(); rx_busy_left = 0; sum = 0;
        if (!never) begin
            for (int q = 0; q < n; q++) begin
                d = (rx_fixed.size() == n) ? rx_fixed[q] : 8'($urandom);
                rxq.push_back(d);
                rb = $urandom_range(3, 0);
                if (q == 0) rx_busy_left = rb; else rx_busy_q.push_back(rb);
                sum += rb;
                exp_rsp.push_back({(q == n - 1), d});
            end
        end
        rx_fixed.delete();
        exp_done_err.push_back(never && n > 0);
        exp_done_reads.push_back((never && n > 0) ? (6 + txn + PL) : (6 + txn + n + sum));
        rsp_idx = 0; stall_cnt = 0;
        d0 = done_cnt;
        bus_if.cmd_valid_i   = 1'b1;
        bus_if.cmd_idx_i     = idx;
        bus_if.cmd_arg_i     = arg;
        bus_if.cmd_rsp_len_i = len;
        @(posedge clk); #1;
        bus_if.cmd_valid_i   = 1'b0;
        bus_if.cmd_idx_i     = 6'($urandom);
        bus_if.cmd_arg_i     = $urandom;
        bus_if.cmd_rsp_len_i = 5'($urandom);
        if (wait_done) begin
            k = 0;
            while (done_cnt == d0 && k < 5000) begin
                @(posedge clk); #1; k++;
            end
            if (k >= 5000) chk("done_wait", 32'(done_cnt), 32'(d0 + 1));
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k, d_before;
        rst_n = 1'b0;
        bus_if.cmd_valid_i = 1'b0; bus_if.cmd_idx_i = '0;
        bus_if.cmd_arg_i = '0; bus_if.cmd_rsp_len_i = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(bus_if.m_wb_cyc_o), 32'h0);
        chk("rst_stb", 32'(bus_if.m_wb_stb_o), 32'h0);
        chk("rst_sel", 32'(bus_if.m_wb_sel_o), 32'h1);
        chk("rst_bus", 32'({bus_if.m_wb_we_o, bus_if.m_wb_adr_o, bus_if.m_wb_dat_o}), 32'h0);
        chk("rst_rsp", 32'({bus_if.rsp_valid_o, bus_if.rsp_last_o, bus_if.rsp_data_o}), 32'h0);
        chk("rst_ctl", 32'({bus_if.cmd_ready_o, done, err}), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CMD0, no response
        run_cmd(6'd0, 32'h0, 5'd0, -1, 0, 0, 1, 8'h95, 1);

        // CMD8 with short response
        rx_fixed = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        run_cmd(6'd8, 32'h0000_01AA, 5'd6, -1, 0, 0, 1, 8'h87, 1);

        // tx FIFO full for 5 reads before the 3rd byte
        run_cmd(6'd17, 32'hDEAD_BEEF, 5'd6, 2, 5, 0, 0, 8'h00, 1);

        // consumer stalls 20 cycles on response byte 2
        stall_byte = 1; stall_len = 20;
        run_cmd(6'd55, 32'h1234_5678, 5'd6, -1, 0, 0, 0, 8'h00, 1);
        stall_byte = -1;

        // R2-length response and an over-length request that saturates
        run_cmd(6'd2, 32'h0, 5'd17, -1, 0, 0, 0, 8'h00, 1);
        run_cmd(6'd9, 32'hABCD_0000, 5'd31, 4, 3, 0, 0, 8'h00, 1);

        // rx FIFO never fills -> timeout
        run_cmd(6'd13, 32'h0001_0000, 5'd6, -1, 0, 1, 0, 8'h00, 1);

        // reset while a strobe waits for ack
        lat_min = 8; lat_max = 8;
        run_cmd(6'd41, 32'h40FF_8000, 5'd6, -1, 0, 0, 0, 8'h00, 0);
        k = 0;
        while (!bus_if.m_wb_stb_o && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("stb_before_reset", 32'(bus_if.m_wb_stb_o), 32'h1);
        @(posedge clk); #1;
        d_before = done_any;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_stb", 32'({bus_if.m_wb_cyc_o, bus_if.m_wb_stb_o}), 32'h0);
        chk("rst_mid_ctl", 32'({bus_if.cmd_ready_o, bus_if.rsp_valid_o, done, err}), 32'h0);
        exp_tx.delete(); exp_rsp.delete(); exp_done_err.delete(); exp_done_reads.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(bus_if.cmd_ready_o), 32'h1);
        chk("no_done_on_reset", 32'(done_any), 32'(d_before));
        lat_min = 1; lat_max = 3;
        run_cmd(6'd41, 32'h40FF_8000, 5'd6, -1, 0, 0, 0, 8'h00, 1);

        // randomized commands
        rdy_rand = 1;
        for (int t = 0; t < 20; t++) begin
            logic [4:0] len;
            bit nv;
            len = 5'($urandom_range(20, 0));
            nv = (len != 0) && ($urandom_range(7, 0) == 0);
            stall_byte = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            stall_len = $urandom_range(10, 1);
            run_cmd(6'($urandom), $urandom, len, int'($urandom_range(5, 0)),
                    int'($urandom_range(PL - 1, 0)), nv, 0, 8'h00, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d, mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
